// File: rtl/prog_seq.sv
// Program sequencer: owns the PC, fetches into IR, and paces each instruction
// through a single commit cycle, stretched by data-memory handshakes.
module prog_seq #(
    parameter int PC_W       = 5,
    parameter int INSTR_W    = 16,
    parameter int DM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               halt_req_i,
    output logic               pm_rd_o,
    output logic [PC_W-1:0]    pm_addr_o,
    input  logic [INSTR_W-1:0] pm_data_i,
    output logic [INSTR_W-1:0] ir_o,
    input  logic               jmp_i,
    input  logic [PC_W-1:0]    jmp_addr_i,
    input  logic               dm_en_i,
    input  logic [1:0]         alu_mux_src_i,
    output logic               dm_req_o,
    input  logic               dm_ack_i,
    output logic               exec_en_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               running_o,
    output logic               halted_o,
    output logic               err_o,
    output logic [15:0]        instr_cnt_o
);

    // state   | meaning
    // IDLE    | out of reset, PC=0, waiting for START
    // FETCH   | PM read strobe at PC
    // LOAD    | capture PM data into IR
    // EXEC    | decoder valid; commit unless a DM access is still pending
    // WAIT_DM | DM request held until ACK or timeout
    // HALT    | stopped at an instruction boundary, IR keeps last instruction
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, EXEC, WAIT_DM, HALT
    } state_t;

    localparam int TMO_W = $clog2(DM_TIMEOUT + 1);
    localparam logic [INSTR_W-1:0] IR_NOP = INSTR_W'(16'hA000);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [15:0]        instr_cnt_q, instr_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               halt_pend_q, halt_pend_d;
    logic               pm_rd_q, pm_rd_d;
    logic               running_q, running_d;
    logic               halted_q, halted_d;
    logic               commit;
    logic               dm_req;
    logic               dm_need;

    assign dm_need = dm_en_i | (alu_mux_src_i == 2'b11);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        instr_cnt_d = instr_cnt_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        halt_pend_d = halt_pend_q;
        commit      = 1'b0;
        dm_req      = 1'b0;

        if (halt_req_i && state_q != HALT)
            halt_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = FETCH;
                    err_d       = 1'b0;
                    instr_cnt_d = 16'h0000;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                ir_d    = pm_data_i;
                state_d = EXEC;
            end
            EXEC: begin
                if (!dm_need || dm_ack_i) begin
                    commit = 1'b1;
                end else begin
                    dm_req  = 1'b1;
                    tmo_d   = TMO_W'(DM_TIMEOUT);
                    state_d = WAIT_DM;
                end
            end
            WAIT_DM: begin
                dm_req = 1'b1;
                if (dm_ack_i) begin
                    commit = 1'b1;
                end else if (tmo_q == TMO_W'(1)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            HALT: begin
                if (start_i) begin
                    state_d = FETCH;
                    err_d   = 1'b0;
                    // START together with HALT_REQ is a single step
                    if (halt_req_i)
                        halt_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            pc_d        = jmp_i ? jmp_addr_i : pc_q + PC_W'(1);
            instr_cnt_d = (instr_cnt_q == 16'hFFFF) ? instr_cnt_q : instr_cnt_q + 16'd1;
            state_d     = halt_pend_q ? HALT : FETCH;
        end

        if (state_d == HALT && state_q != HALT)
            halt_pend_d = 1'b0;

        pm_rd_d   = (state_d == FETCH);
        running_d = (state_d == FETCH) || (state_d == LOAD) ||
                    (state_d == EXEC)  || (state_d == WAIT_DM);
        halted_d  = (state_d == HALT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            ir_q        <= IR_NOP;
            instr_cnt_q <= 16'h0000;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            pm_rd_q     <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instr_cnt_q <= instr_cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            halt_pend_q <= halt_pend_d;
            pm_rd_q     <= pm_rd_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign pm_rd_o     = pm_rd_q;
    assign pm_addr_o   = pc_q;
    assign ir_o        = ir_q;
    assign dm_req_o    = dm_req;
    assign exec_en_o   = commit;
    assign pc_o        = pc_q;
    assign running_o   = running_q;
    assign halted_o    = halted_q;
    assign err_o       = err_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: synchronous PM model, a toy decoder driven from
// IR, and hand-timed DM acknowledges.
module tb_prog_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        pm_rd;
    logic [4:0]  pm_addr;
    logic [15:0] pm_data;
    logic [15:0] ir;
    logic        jmp;
    logic [4:0]  jmp_addr;
    logic        dm_en;
    logic [1:0]  alu_src;
    logic        dm_req;
    logic        dm_ack;
    logic        exec_en;
    logic [4:0]  pc;
    logic        running;
    logic        halted;
    logic        err;
    logic [15:0] instr_cnt;

    logic [15:0] mem [32];
    int n_chk  = 0;
    int n_pass = 0;
    int ex_cnt;
    int req_cnt;

    always #5 clk = ~clk;

    prog_seq #(.PC_W(5), .INSTR_W(16), .DM_TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .halt_req_i(halt_req),
        .pm_rd_o(pm_rd), .pm_addr_o(pm_addr), .pm_data_i(pm_data),
        .ir_o(ir), .jmp_i(jmp), .jmp_addr_i(jmp_addr), .dm_en_i(dm_en),
        .alu_mux_src_i(alu_src), .dm_req_o(dm_req), .dm_ack_i(dm_ack),
        .exec_en_o(exec_en), .pc_o(pc), .running_o(running),
        .halted_o(halted), .err_o(err), .instr_cnt_o(instr_cnt)
    );

    // toy encoding: [11]=jump, [10]=store, [9:8]=operand source, [4:0]=target
    assign jmp      = ir[11];
    assign dm_en    = ir[10];
    assign alu_src  = ir[9:8];
    assign jmp_addr = ir[4:0];

    always @(posedge clk) if (pm_rd) pm_data <= mem[pm_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; dm_ack = 1'b0; pm_data = 16'h0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000;
        mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'hA000;
        tick(); tick();
        check("rst_pm_rd", pm_rd, 0);
        check("rst_dm_req", dm_req, 0);
        check("rst_exec_en", exec_en, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 16'hA000);

        // three straight-line instructions, halt requested during the third LOAD
        rst = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0;             // cycle 1
        check("seq_pm_rd", pm_rd, 1);
        check("seq_addr0", pm_addr, 0);
        tick(); tick();                                  // 3
        check("seq_exec1", exec_en, 1);
        tick();                                          // 4
        check("seq_addr1", pm_addr, 1);
        check("seq_exec_gap", exec_en, 0);
        check("seq_cnt1", instr_cnt, 1);
        tick(); tick();                                  // 6
        check("seq_exec2", exec_en, 1);
        tick();                                          // 7
        check("seq_addr2", pm_addr, 2);
        tick(); halt_req = 1'b1;                         // 8 (LOAD)
        tick(); halt_req = 1'b0;                         // 9
        check("seq_exec3", exec_en, 1);
        check("seq_ir", ir, 16'hA000);
        tick();                                          // 10
        check("seq_halted", halted, 1);
        check("seq_running", running, 0);
        check("seq_cnt3", instr_cnt, 3);
        check("seq_pc3", pc, 3);

        // jump 4->20, 20->31, then wrap 31->0
        mem[3] = 16'h1000; mem[4] = 16'h0814; mem[20] = 16'h081F; mem[31] = 16'h2000;
        start = 1'b1; tick(); start = 1'b0;              // 1
        check("jmp_running", running, 1);
        check("jmp_addr3", pm_addr, 3);
        tick(); tick(); tick();
        check("jmp_addr4", pm_addr, 4);
        tick(); tick(); tick();
        check("jmp_target20", pm_addr, 20);
        tick(); tick(); tick();
        check("jmp_target31", pm_addr, 31);
        tick(); tick(); tick();                          // 13
        check("wrap_addr0", pm_addr, 0);
        halt_req = 1'b1; tick(); halt_req = 1'b0;        // 14
        tick(); tick();                                  // 16
        check("jmp_halted", halted, 1);
        check("jmp_pc", pc, 1);
        check("jmp_cnt", instr_cnt, 8);

        // load from DM, ACK four cycles after EXEC entry
        mem[1] = 16'h0300; mem[2] = 16'h1000;
        start = 1'b1; tick(); start = 1'b0;              // 1
        check("ld_addr", pm_addr, 1);
        tick(); tick();                                  // 3
        req_cnt = dm_req ? 1 : 0;
        ex_cnt  = exec_en ? 1 : 0;
        for (int c = 4; c <= 6; c++) begin
            tick();
            req_cnt += dm_req ? 1 : 0;
            ex_cnt  += exec_en ? 1 : 0;
        end
        tick(); dm_ack = 1'b1; #1;                       // 7
        req_cnt += dm_req ? 1 : 0;
        check("ld_exec_on_ack", exec_en, 1);
        check("ld_no_early_exec", ex_cnt, 0);
        check("ld_req_cycles", req_cnt, 5);
        tick(); dm_ack = 1'b0;                           // 8
        check("ld_req_drop", dm_req, 0);
        check("ld_pc_inc", pc, 2);
        halt_req = 1'b1; tick(); halt_req = 1'b0;        // 9
        tick(); tick();                                  // 11
        check("ld_halted", halted, 1);
        check("ld_cnt", instr_cnt, 10);

        // store with no ACK: timeout fault
        mem[3] = 16'h0400;
        start = 1'b1; tick(); start = 1'b0;              // 1
        tick(); tick();                                  // 3
        check("tmo_req", dm_req, 1);
        ex_cnt = exec_en ? 1 : 0;
        req_cnt = 0;
        for (int c = 4; c <= 18; c++) begin
            tick();
            req_cnt += dm_req ? 1 : 0;
            ex_cnt  += exec_en ? 1 : 0;
        end
        check("tmo_wait_cycles", req_cnt, 15);
        check("tmo_no_exec", ex_cnt, 0);
        tick();                                          // 19
        check("tmo_err", err, 1);
        check("tmo_halted", halted, 1);
        check("tmo_pc", pc, 3);
        check("tmo_req_off", dm_req, 0);
        check("tmo_cnt", instr_cnt, 10);

        // single step from HALT refetches the faulted store, ACK in EXEC
        start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0; halt_req = 1'b0;
        check("step_err_clr", err, 0);
        check("step_refetch", pm_addr, 3);
        tick(); tick(); dm_ack = 1'b1; #1;               // 3
        check("step_exec", exec_en, 1);
        check("step_no_req", dm_req, 0);
        tick(); dm_ack = 1'b0;                           // 4
        check("step_halted", halted, 1);
        check("step_pc", pc, 4);
        check("step_cnt", instr_cnt, 11);

        // reset while waiting on DM
        mem[4] = 16'h0400;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();                  // 5 (WAIT_DM)
        check("rstw_req_before", dm_req, 1);
        #2 rst = 1'b1; #1;
        check("rstw_req", dm_req, 0);
        check("rstw_running", running, 0);
        check("rstw_pc", pc, 0);
        check("rstw_ir", ir, 16'hA000);
        check("rstw_cnt", instr_cnt, 0);
        check("rstw_exec", exec_en, 0);
        tick(); rst = 1'b0; tick();

        // saturation: preload the counter near the top, then 300 commits
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000;
        start = 1'b1; tick(); start = 1'b0;              // 1
        force dut.instr_cnt_q = 16'hFF00;
        tick();                                          // 2
        release dut.instr_cnt_q;
        for (int c = 3; c <= 901; c++) begin
            tick();
            if (c == 3 * 254 + 1) check("sat_fffe", instr_cnt, 16'hFFFE);
            if (c == 3 * 255 + 1) check("sat_ffff", instr_cnt, 16'hFFFF);
        end
        check("sat_hold", instr_cnt, 16'hFFFF);
        check("sat_running", running, 1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
